// File: rtl/seg_scan_ctrl_if.sv
// seg_scan_ctrl_if: display data, load handshake and scan outputs between a
// display client (master) and seg_scan_ctrl (slave).
interface seg_scan_ctrl_if #(
    parameter int unsigned NUM_DIGITS = 6
) ();
    logic [4*NUM_DIGITS-1:0] digits_in;
    logic                    load_req;
    logic [NUM_DIGITS-1:0]   blank_mask;
    logic                    load_ack;
    logic                    frame_start;
    logic [4:0]              hex_code;
    logic [NUM_DIGITS-1:0]   digit_sel;

    modport master (
        output digits_in, load_req, blank_mask,
        input  load_ack, frame_start, hex_code, digit_sel
    );

    modport slave (
        input  digits_in, load_req, blank_mask,
        output load_ack, frame_start, hex_code, digit_sel
    );
endinterface

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: time-multiplexed scan of NUM_DIGITS common-anode digits onto
// one shared hex decoder. Display data is shadowed at frame wrap only, so a
// new value never tears mid-frame. Each digit slot starts with GUARD dark
// cycles to suppress ghosting.
// Optional build macro SEG_LZ_BLANK_EN enables leading-zero suppression.
module seg_scan_ctrl #(
    parameter int unsigned NUM_DIGITS = 6,
    parameter int unsigned DIV        = 50000,
    parameter int unsigned GUARD      = 8
) (
    input logic            clk,
    input logic            resetN,
    seg_scan_ctrl_if.slave bus
);
    localparam int unsigned IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int unsigned TW = $clog2(DIV);
    localparam int unsigned GW = (GUARD > 1) ? $clog2(GUARD) : 1;

    localparam logic [IW-1:0] LAST_IDX   = IW'(NUM_DIGITS - 1);
    localparam logic [TW-1:0] LAST_TICK  = TW'(DIV - 1);
    localparam logic [GW-1:0] LAST_GUARD = GW'(GUARD - 1);
    localparam logic [4:0]    HEX_BLANK  = 5'h10;

    typedef enum logic {st_guard, st_drive} state_e;

    state_e                  state_q, state_d;
    logic [TW-1:0]           tick_cnt_q, tick_cnt_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic [GW-1:0]           guard_cnt_q, guard_cnt_d;
    logic [4*NUM_DIGITS-1:0] shadow_q, shadow_d;
    logic [NUM_DIGITS-1:0]   lz_d;
    logic [NUM_DIGITS-1:0]   blank_eff;
    logic [NUM_DIGITS-1:0]   sel_d, digit_sel_q;
    logic [4:0]              hex_d, hex_code_q;
    logic                    load_ack_q, frame_start_q;
    logic                    tick, wrap, capture;

    assign tick    = (tick_cnt_q == LAST_TICK);
    assign wrap    = tick && (idx_q == LAST_IDX);
    assign capture = wrap && bus.load_req;

`ifdef SEG_LZ_BLANK_EN
    logic [NUM_DIGITS-1:0] lz_q, lz_new;
    logic                  lz_all_zero;

    // Blank zero nibbles from the top digit down to the first non-zero one; digit 0 never.
    always_comb begin
        lz_all_zero = 1'b1;
        lz_new      = '0;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            lz_all_zero = lz_all_zero && (bus.digits_in[4*i +: 4] == 4'h0);
            lz_new[i]   = lz_all_zero;
        end
    end

    assign lz_d = capture ? lz_new : lz_q;
`else
    assign lz_d = '0;
`endif

    // Next-state for slot timing, scan index, guard FSM, shadow and decoder outputs.
    always_comb begin
        tick_cnt_d  = tick ? '0 : tick_cnt_q + 1'b1;
        idx_d       = idx_q;
        state_d     = state_q;
        guard_cnt_d = guard_cnt_q;
        if (tick) begin
            // Slot boundary wins over a same-cycle guard expiry.
            idx_d       = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
            state_d     = st_guard;
            guard_cnt_d = '0;
        end else if (state_q == st_guard) begin
            guard_cnt_d = guard_cnt_q + 1'b1;
            if (guard_cnt_q == LAST_GUARD) begin
                state_d = st_drive;
            end
        end

        shadow_d  = capture ? bus.digits_in : shadow_q;
        blank_eff = bus.blank_mask | lz_d;

        sel_d = '1;
        hex_d = HEX_BLANK;
        if (state_d == st_drive) begin
            sel_d[idx_d] = 1'b0;
            hex_d = blank_eff[idx_d] ? HEX_BLANK : {1'b0, shadow_d[4*idx_d +: 4]};
        end
    end

    // All state and registered outputs; reset blanks the display immediately.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q       <= st_guard;
            tick_cnt_q    <= '0;
            idx_q         <= '0;
            guard_cnt_q   <= '0;
            shadow_q      <= '0;
            digit_sel_q   <= '1;
            hex_code_q    <= HEX_BLANK;
            load_ack_q    <= 1'b0;
            frame_start_q <= 1'b0;
`ifdef SEG_LZ_BLANK_EN
            lz_q          <= '0;
`endif
        end else begin
            state_q       <= state_d;
            tick_cnt_q    <= tick_cnt_d;
            idx_q         <= idx_d;
            guard_cnt_q   <= guard_cnt_d;
            shadow_q      <= shadow_d;
            digit_sel_q   <= sel_d;
            hex_code_q    <= hex_d;
            load_ack_q    <= capture;
            frame_start_q <= wrap;
`ifdef SEG_LZ_BLANK_EN
            lz_q          <= lz_d;
`endif
        end
    end

    assign bus.digit_sel   = digit_sel_q;
    assign bus.hex_code    = hex_code_q;
    assign bus.load_ack    = load_ack_q;
    assign bus.frame_start = frame_start_q;
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb_seg_scan_ctrl: scoreboard bench for seg_scan_ctrl (4 digits, DIV=4, GUARD=1).
// The stimulus thread queues the expected output of every cycle; a monitor pops
// and compares on each falling edge while enabled.
module tb_seg_scan_ctrl;
    localparam int unsigned ND = 4;

`ifdef SEG_LZ_BLANK_EN
    localparam logic [4:0] ZB = 5'h10;  // leading zero digit
`else
    localparam logic [4:0] ZB = 5'h00;
`endif

    typedef struct packed {
        logic [3:0] sel;
        logic [4:0] hex;
        logic       fs;
        logic       ack;
    } out_t;

    logic clk;
    logic resetN;
    int   checks;
    int   errors;
    int   cyc;
    logic mon_en;
    out_t exp_q[$];

    seg_scan_ctrl_if #(.NUM_DIGITS(ND)) bus ();

    seg_scan_ctrl #(
        .NUM_DIGITS(ND),
        .DIV       (4),
        .GUARD     (1)
    ) dut (
        .clk   (clk),
        .resetN(resetN),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Cycle index since reset release: after posedge k, cyc == k.
    always @(posedge clk or negedge resetN) begin
        if (!resetN) cyc <= 0;
        else         cyc <= cyc + 1;
    end

    // Monitor: compare every cycle's outputs against the queued expectation.
    always @(negedge clk) begin
        if (mon_en) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_output k=%0d sel=%b hex=%h", cyc, bus.digit_sel,
                         bus.hex_code);
            end else begin
                out_t e;
                e = exp_q.pop_front();
                if (bus.digit_sel !== e.sel || bus.hex_code !== e.hex ||
                    bus.frame_start !== e.fs || bus.load_ack !== e.ack) begin
                    errors++;
                    $display("FAIL scan_out k=%0d got sel=%b hex=%h fs=%b ack=%b want sel=%b hex=%h fs=%b ack=%b",
                             cyc, bus.digit_sel, bus.hex_code, bus.frame_start, bus.load_ack,
                             e.sel, e.hex, e.fs, e.ack);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s got %h want %h", name, act, want);
        end
    endtask

    // One frame: per digit, one dark guard cycle then three driven cycles.
    task automatic push_frame(input logic [4:0] h0, input logic [4:0] h1,
                              input logic [4:0] h2, input logic [4:0] h3,
                              input logic fs, input logic ack);
        logic [4:0] h [4];
        logic [3:0] one_hot;
        out_t       e;
        h[0] = h0; h[1] = h1; h[2] = h2; h[3] = h3;
        for (int i = 0; i < 4; i++) begin
            e.sel = 4'hF;
            e.hex = 5'h10;
            e.fs  = (i == 0) ? fs : 1'b0;
            e.ack = (i == 0) ? ack : 1'b0;
            exp_q.push_back(e);
            one_hot = 4'b0001 << i;
            for (int j = 0; j < 3; j++) begin
                e.sel = ~one_hot;
                e.hex = h[i];
                e.fs  = 1'b0;
                e.ack = 1'b0;
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic wait_k(input int n);
        int g;
        g = 0;
        while (cyc < n && g < 500) begin
            @(posedge clk);
            #1;
            g++;
        end
        checks++;
        if (cyc != n) begin
            errors++;
            $display("FAIL wait_cycle got %0d want %0d", cyc, n);
        end
    endtask

    task automatic check_dark(input string tag);
        chk({tag, "_digit_sel"}, 32'(bus.digit_sel), 32'hF);
        chk({tag, "_hex_code"}, 32'(bus.hex_code), 32'h10);
        chk({tag, "_load_ack"}, 32'(bus.load_ack), 32'h0);
        chk({tag, "_frame_start"}, 32'(bus.frame_start), 32'h0);
    endtask

    initial begin
        int g;
        checks         = 0;
        errors         = 0;
        mon_en         = 1'b0;
        resetN         = 1'b0;
        bus.digits_in  = '0;
        bus.load_req   = 1'b0;
        bus.blank_mask = '0;

        repeat (3) @(negedge clk);
        check_dark("reset");

        // Full expected run; load data and blank mask changes are timed below.
        @(posedge clk);
        #1;
        push_frame(5'h00, 5'h00, 5'h00, 5'h00, 1'b0, 1'b0);  // free scan, empty shadow
        push_frame(5'h00, 5'h00, 5'h00, 5'h00, 1'b1, 1'b0);  // request pending, no ack yet
        push_frame(5'h04, 5'h03, 5'h02, 5'h01, 1'b1, 1'b1);  // 16'h1234 captured
        push_frame(5'h04, 5'h10, 5'h02, 5'h01, 1'b1, 1'b1);  // re-ack, digit 1 masked
        push_frame(5'h00, 5'h05, ZB, ZB, 1'b1, 1'b1);        // 16'h0050
        push_frame(5'h00, ZB, ZB, ZB, 1'b1, 1'b1);           // 16'h0000
        push_frame(5'h00, ZB, ZB, ZB, 1'b1, 1'b0);           // request dropped
        mon_en = 1'b1;
        @(negedge clk);
        resetN = 1'b1;

        wait_k(21);                    // digit 1 slot of frame 1
        bus.load_req  = 1'b1;
        bus.digits_in = 16'h1234;
        wait_k(44);
        bus.blank_mask = 4'b0010;
        wait_k(50);
        bus.digits_in = 16'h0050;
        wait_k(60);
        bus.blank_mask = 4'b0000;
        wait_k(66);
        bus.digits_in = 16'h0000;
        wait_k(82);
        bus.load_req = 1'b0;

        // Asynchronous reset in the middle of digit 2's drive phase.
        wait_k(106);
        chk("pre_reset_digit_sel", 32'(bus.digit_sel), 32'hB);
        mon_en = 1'b0;
        exp_q.delete();
        #1;
        resetN = 1'b0;
        #1;
        check_dark("async_reset");

        repeat (2) @(negedge clk);
        @(posedge clk);
        #1;
        push_frame(5'h00, 5'h00, 5'h00, 5'h00, 1'b0, 1'b0);  // shadow cleared
        push_frame(5'h00, 5'h00, 5'h00, 5'h00, 1'b1, 1'b0);
        mon_en = 1'b1;
        @(negedge clk);
        resetN = 1'b1;

        g = 0;
        while (exp_q.size() != 0 && g < 200) begin
            @(posedge clk);
            #1;
            g++;
        end
        mon_en = 1'b0;
        chk("queue_drained", 32'(exp_q.size()), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
